// File: rtl/tx_resp_sched.sv
// Response scheduler: queues ALU (2-byte) and RF (1-byte) results and serialises them to a UART.
// Strobe-to-TX_VALID latency is 2 cycles from idle; a byte is held until TX_BUSY acknowledges it.
module tx_resp_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ALU_SEND,
  input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
  input  logic                    RF_SEND,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  input  logic                    TX_BUSY,
  input  logic                    OVF_CLR,
  output logic                    TX_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    Q_FULL,
  output logic                    Q_EMPTY,
  output logic                    OVERFLOW,
  output logic                    SCHED_BUSY
);
  localparam int W2 = 2 * DATA_WIDTH;
  localparam int EW = W2 + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI} state_t;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d, free_slots;
  logic                  ovf_q, ovf_d;
  logic                  alu_ok, rf_ok, drop, pop;
  logic [EW-1:0]         head;
  state_t                state_q;
  logic [DATA_WIDTH:0]   frame_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  // Admission is judged on start-of-cycle occupancy; ALU gets the first free slot.
  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    alu_ok     = ALU_SEND && (free_slots != '0);
    rf_ok      = RF_SEND && (alu_ok ? (free_slots >= CW'(2)) : (free_slots != '0));
    drop       = (ALU_SEND && !alu_ok) || (RF_SEND && !rf_ok);
    pop        = (state_q == IDLE) && (count_q != '0);
    head       = mem_q[rptr_q];
    count_d    = count_q + CW'(alu_ok) + CW'(rf_ok) - CW'(pop);
    wptr_d     = wptr_q + AW'(alu_ok) + AW'(rf_ok);
    rptr_d     = rptr_q + AW'(pop);
    ovf_d      = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (alu_ok) mem_q[wptr_q] <= {1'b1, ALU_DATA};
      if (rf_ok)  mem_q[alu_ok ? wptr_q + AW'(1) : wptr_q] <= {1'b0, DATA_WIDTH'(0), RF_DATA};
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // The frame keeps only the type bit and high byte; the low byte goes straight to TX_DATA at pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q    <= SEND_LO;
          frame_q    <= {head[W2], head[W2-1:DATA_WIDTH]};
          tx_valid_q <= 1'b1;
          tx_data_q  <= head[DATA_WIDTH-1:0];
        end
        SEND_LO: if (TX_BUSY) begin
          state_q    <= WAIT_LO;
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end
        WAIT_LO: if (!TX_BUSY) begin
          if (frame_q[DATA_WIDTH]) begin
            state_q    <= SEND_HI;
            tx_valid_q <= 1'b1;
            tx_data_q  <= frame_q[DATA_WIDTH-1:0];
          end else begin
            state_q    <= IDLE;
          end
        end
        SEND_HI: if (TX_BUSY) begin
          state_q    <= WAIT_HI;
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end
        WAIT_HI: if (!TX_BUSY) state_q <= IDLE;
        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end
      endcase
    end
  end

  assign TX_VALID   = tx_valid_q;
  assign TX_DATA    = tx_data_q;
  assign Q_FULL     = (count_q == CW'(DEPTH));
  assign Q_EMPTY    = (count_q == '0);
  assign OVERFLOW   = ovf_q;
  assign SCHED_BUSY = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_tx_resp_sched.sv
// Directed bench for tx_resp_sched: table of per-cycle vectors plus hand-written stall, reset and wrap sequences.
module tb_tx_resp_sched;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ALU_SEND = 1'b0;
  logic [2*DW-1:0] ALU_DATA = '0;
  logic          RF_SEND = 1'b0;
  logic [DW-1:0] RF_DATA = '0;
  logic          TX_BUSY = 1'b0;
  logic          OVF_CLR = 1'b0;
  logic          TX_VALID;
  logic [DW-1:0] TX_DATA;
  logic          Q_FULL, Q_EMPTY, OVERFLOW, SCHED_BUSY;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [7:0] got[$];

  always #5 CLK = ~CLK;

  tx_resp_sched #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_SEND(ALU_SEND), .ALU_DATA(ALU_DATA),
    .RF_SEND(RF_SEND), .RF_DATA(RF_DATA),
    .TX_BUSY(TX_BUSY), .OVF_CLR(OVF_CLR),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .Q_FULL(Q_FULL), .Q_EMPTY(Q_EMPTY),
    .OVERFLOW(OVERFLOW), .SCHED_BUSY(SCHED_BUSY)
  );

  typedef struct {
    bit        rst;
    bit        as;
    bit [15:0] ad;
    bit        rs;
    bit [7:0]  rd;
    bit        busy;
    bit        clr;
    bit [12:0] exp;   // {valid, data, full, empty, ovf, sched_busy}
  } vec_t;

  vec_t vecs[$];

  localparam logic [12:0] RESET_OUTS = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic vec_t mk(bit rst, bit as, bit [15:0] ad, bit rs, bit [7:0] rd, bit busy, bit clr,
                              bit v, bit [7:0] d, bit f, bit e, bit o, bit sb);
    vec_t r;
    r.rst = rst; r.as = as; r.ad = ad; r.rs = rs; r.rd = rd; r.busy = busy; r.clr = clr;
    r.exp = {v, d, f, e, o, sb};
    return r;
  endfunction

  function automatic logic [12:0] outs();
    return {TX_VALID, TX_DATA, Q_FULL, Q_EMPTY, OVERFLOW, SCHED_BUSY};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_SEND = 1'b0; ALU_DATA = '0; RF_SEND = 1'b0; RF_DATA = '0;
    TX_BUSY = 1'b0; OVF_CLR = 1'b0;
  endtask

  task automatic do_reset(input string name);
    RST = 1'b0;
    idle_inputs();
    #1;
    check(name, 32'(outs()), 32'(RESET_OUTS));
    step();
    RST = 1'b1;
  endtask

  // Acknowledge every offered byte with a one-cycle busy pulse until the scheduler goes quiet.
  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (TX_VALID) begin
        got.push_back(TX_DATA);
        TX_BUSY = 1'b1;
      end else begin
        TX_BUSY = 1'b0;
      end
      step();
      if (!SCHED_BUSY && !TX_VALID) begin
        done = 1'b1;
        break;
      end
    end
    TX_BUSY = 1'b0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;

    // Single ALU frame A55A
    vecs.push_back(mk(1,1,16'hA55A,0,8'h00,0,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 1,8'h5A,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 1,8'h5A,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 1,8'hA5,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 0,8'h00,0,1,0,0));
    // Simultaneous ALU 1234 + RF 77
    vecs.push_back(mk(1,1,16'h1234,1,8'h77,0,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 1,8'h34,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 1,8'h12,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 1,8'h77,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,0,1,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 0,8'h00,0,1,0,0));
    // Overflow: RF pushes with TX_BUSY stuck high, then ALU+RF into one free slot
    vecs.push_back(mk(1,0,16'h0000,1,8'h01,1,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,1,8'h02,1,0, 1,8'h01,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,1,8'h03,1,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,1,8'h04,1,0, 0,8'h00,0,0,0,1));
    vecs.push_back(mk(0,1,16'hBEEF,1,8'h05,1,0, 0,8'h00,1,0,1,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,0, 0,8'h00,1,0,1,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,1, 0,8'h00,1,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,1,8'h06,1,1, 0,8'h00,1,0,1,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,1,1, 0,8'h00,1,0,0,1));
    vecs.push_back(mk(0,0,16'h0000,0,8'h00,0,0, 0,8'h00,1,0,0,1));
    // Full queue: the IDLE pop in this cycle must not make room for the RF push
    vecs.push_back(mk(0,0,16'h0000,1,8'h07,0,0, 1,8'h02,0,0,1,1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset($sformatf("reset_before_row%0d", i));
      ALU_SEND = vecs[i].as; ALU_DATA = vecs[i].ad;
      RF_SEND  = vecs[i].rs; RF_DATA  = vecs[i].rd;
      TX_BUSY  = vecs[i].busy; OVF_CLR = vecs[i].clr;
      step();
      check($sformatf("row%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Stall: byte held for 20 cycles without acknowledgement
    do_reset("reset_stall");
    ALU_SEND = 1'b1; ALU_DATA = 16'hC3A7;
    step();
    ALU_SEND = 1'b0;
    step();
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("stall_c%0d", c), {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hA7});
    end
    got.delete();
    drain(50);
    check("stall_nbytes", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("stall_b0", 32'(got[0]), 32'hA7);
      check("stall_b1", 32'(got[1]), 32'hC3);
    end

    // Asynchronous reset in WAIT_LO with two entries queued
    do_reset("reset_mid_pre");
    ALU_SEND = 1'b1; ALU_DATA = 16'h1111;
    step();
    ALU_DATA = 16'h2233; RF_SEND = 1'b1; RF_DATA = 8'h44;
    step();
    ALU_SEND = 1'b0; RF_SEND = 1'b0; TX_BUSY = 1'b1;
    step();
    check("mid_wait_lo", 32'(outs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
    #2 RST = 1'b0;
    TX_BUSY = 1'b0;
    #1;
    check("mid_async_reset", 32'(outs()), 32'(RESET_OUTS));
    step();
    RST = 1'b1;
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (TX_VALID) nv++;
    end
    check("mid_no_bytes", 32'(nv), 32'd0);
    check("mid_idle", 32'(outs()), 32'(RESET_OUTS));

    // Wrap: 10 RF bytes in bursts of 3 through a 4-entry queue
    do_reset("reset_wrap");
    got.delete();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < ((b < 3) ? 3 : 1); k++) begin
        RF_SEND = 1'b1;
        RF_DATA = 8'(8'h10 + b * 3 + k);
        step();
      end
      RF_SEND = 1'b0;
      drain(100);
    end
    check("wrap_nbytes", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++)
      check($sformatf("wrap_b%0d", i), 32'(got[i]), 32'(8'h10 + i));
    check("wrap_overflow", 32'(OVERFLOW), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
